// File: rtl/countdown_timer_if.sv
// countdown_timer_if: command, preset and display/status signals of the
// countdown timer. The master side (control logic / bench) drives commands
// and presets; the slave side (countdown_timer) drives digits and status.
interface countdown_timer_if;
    logic       pulse_1s;
    logic       start;
    logic       pause;
    logic       load;
    logic [6:0] set_min;
    logic [5:0] set_sec;
    logic       enable_pulse_1s;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;

    modport master (
        output pulse_1s, start, pause, load, set_min, set_sec,
        input  enable_pulse_1s, min_tens, min_ones, sec_tens, sec_ones,
               running, done
    );

    modport slave (
        input  pulse_1s, start, pause, load, set_min, set_sec,
        output enable_pulse_1s, min_tens, min_ones, sec_tens, sec_ones,
               running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown driven by an external 1 s tick.
// States IDLE/RUN/PAUSE/DONE; commands load > start > pause.
// Optional feature macro: AUTO_RELOAD_EN (expiry reloads the preset and keeps
// running, done becomes a one-cycle pulse). Default build holds in DONE.
module countdown_timer #(
    parameter int MAX_MIN = 59
) (
    input logic             clk,
    input logic             rst,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] MAX_MIN_C = 7'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_C = 6'd59;

    // Digits packed as {min_tens, min_ones, sec_tens, sec_ones}
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pre_q, pre_d;
    logic        enable_q, enable_d;
    logic        running_q, running_d;
    logic        done_q, done_d;

    logic [6:0]  min_clamped;
    logic [5:0]  sec_clamped;
    logic [15:0] load_bcd;
    logic [15:0] cnt_dec;
    logic        cnt_zero;
    logic        cnt_one;
    logic        pre_zero;
    logic        expire;

    // Binary 0..99 to two BCD digits
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = v / 7'd10;
        ones = v - tens * 7'd10;
        return ({1'b0, tens} << 4) | {1'b0, ones};
    endfunction

    // Clamp presets and convert them to BCD
    always_comb begin
        min_clamped = (bus.set_min > MAX_MIN_C) ? MAX_MIN_C : bus.set_min;
        sec_clamped = (bus.set_sec > MAX_SEC_C) ? MAX_SEC_C : bus.set_sec;
        load_bcd    = {to_bcd(min_clamped), to_bcd({1'b0, sec_clamped})};
    end

    // One-second BCD decrement with borrow chain; only used when count != 0
    always_comb begin
        cnt_dec = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            cnt_dec[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                cnt_dec[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    cnt_dec[11:8]  = 4'd9;
                    cnt_dec[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Next state, count and preset; registered outputs derive from next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        expire    = 1'b0;
        cnt_zero  = (cnt_q == 16'h0000);
        cnt_one   = (cnt_q == 16'h0001);
        pre_zero  = (pre_q == 16'h0000);

        if (bus.load && state_q != RUN) begin
            pre_d   = load_bcd;
            cnt_d   = load_bcd;
            state_d = IDLE;
        end else if (bus.start && state_q != RUN) begin
            case (state_q)
                IDLE:    if (!cnt_zero) state_d = RUN;
                PAUSE:   state_d = RUN;
                DONE: begin
                    cnt_d   = pre_q;
                    state_d = pre_zero ? IDLE : RUN;
                end
                default: state_d = state_q;
            endcase
        end else if (state_q == RUN) begin
            // A tick and pause in the same cycle both act; expiry beats pause
            if (bus.pulse_1s && !cnt_zero) begin
                if (cnt_one) begin
                    expire = 1'b1;
`ifdef AUTO_RELOAD_EN
                    cnt_d   = pre_q;
                    state_d = bus.pause ? PAUSE : RUN;
`else
                    cnt_d   = 16'h0000;
                    state_d = DONE;
`endif
                end else begin
                    cnt_d   = cnt_dec;
                    state_d = bus.pause ? PAUSE : RUN;
                end
            end else if (bus.pause) begin
                state_d = PAUSE;
            end
        end

        enable_d  = (state_d == RUN);
        running_d = (state_d == RUN);
`ifdef AUTO_RELOAD_EN
        done_d    = expire;
`else
        done_d    = (state_d == DONE);
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            enable_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            enable_q  <= enable_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.enable_pulse_1s = enable_q;
    assign bus.running         = running_q;
    assign bus.done            = done_q;
    assign bus.min_tens        = cnt_q[15:12];
    assign bus.min_ones        = cnt_q[11:8];
    assign bus.sec_tens        = cnt_q[7:4];
    assign bus.sec_ones        = cnt_q[3:0];

endmodule
